// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {pc, instr, fault}.
// Optional IFQ_BYPASS_EN: an empty queue forwards the fetch entry straight to decode.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [XLEN-1:0]          fetch_instr,
    input  logic                     fetch_fault,
    input  logic                     StallD,
    input  logic                     FlushD,
    output logic                     ValidD,
    output logic [XLEN-1:0]          InstrD,
    output logic [XLEN-1:0]          PCD,
    output logic                     FaultD,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } ifq_entry_t;

    ifq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    ifq_entry_t head;
    logic       q_valid, byp, push, pop, wr_en;

    assign fetch_ready = (count_q != CW'(DEPTH));
    assign push        = fetch_valid & fetch_ready;
    assign count       = count_q;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        q_valid = (count_q != '0);
        byp     = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp     = (count_q == '0) & ~FlushD & fetch_valid;
`endif
        ValidD  = q_valid | byp;
        InstrD  = NOP;
        PCD     = '0;
        FaultD  = 1'b0;
        if (byp) begin
            InstrD = fetch_instr;
            PCD    = fetch_pc;
            FaultD = fetch_fault;
        end else if (q_valid) begin
            InstrD = head.instr;
            PCD    = head.pc;
            FaultD = head.fault;
        end
        pop   = q_valid & ~StallD & ~FlushD;
        // A bypassed entry that decode consumes right away never occupies a slot.
        wr_en = push & ~FlushD & ~(byp & ~StallD);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (FlushD) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: every read is gated by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= '{pc: fetch_pc, instr: fetch_instr, fault: fetch_fault};
    end

endmodule
